// File: rtl/and16_arbiter_if.sv
// ---------------------------------------------------------------------------
// and16_arbiter_if
// Bundle of the requester-side signals of the shared 16-bit AND arbiter.
//   req    [3:0]  : per-requester request, held until gnt is seen
//   a_bus  [63:0] : operand A, requester i on bits [16i+15:16i]
//   b_bus  [63:0] : operand B, same packing as a_bus
//   gnt    [3:0]  : one-hot one-cycle pulse, operands captured
//   done   [3:0]  : one-hot one-cycle pulse, result valid for that requester
//   result [15:0] : AND of the captured operands, held until next op
//   busy          : arbiter is executing or returning a result
//   lock   [3:0]  : owner re-grant request (only with AND16_ARB_LOCK_EN)
// Modports: master = requester side, slave = arbiter side.
// Optional feature macro: AND16_ARB_LOCK_EN.
// ---------------------------------------------------------------------------
interface and16_arbiter_if;
    logic [3:0]  req;
    logic [63:0] a_bus;
    logic [63:0] b_bus;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [15:0] result;
    logic        busy;
`ifdef AND16_ARB_LOCK_EN
    logic [3:0]  lock;
`endif

    modport master (
`ifdef AND16_ARB_LOCK_EN
        output lock,
`endif
        output req, a_bus, b_bus,
        input  gnt, done, result, busy
    );

    modport slave (
`ifdef AND16_ARB_LOCK_EN
        input  lock,
`endif
        input  req, a_bus, b_bus,
        output gnt, done, result, busy
    );
endinterface

// File: rtl/and16_arbiter.sv
// ---------------------------------------------------------------------------
// and16_arbiter
// Round-robin sequencing arbiter sharing one 16-bit bitwise AND array
// (and16_gate, built from and_gate cells) among four requesters.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high
//   bus    : and16_arbiter_if.slave (req/a_bus/b_bus in, gnt/done/result/busy out,
//            plus lock in when AND16_ARB_LOCK_EN is defined)
// Parameter:
//   RR_RESET_PTR : requester index (0-3) with highest priority after reset
// Optional feature macro: AND16_ARB_LOCK_EN (owner re-grant lock, DONE only).
// Sequence per op: IDLE/DONE arbitrate and capture -> EXEC evaluates the
// shared AND -> DONE returns the result and may already grant the next op.
// ---------------------------------------------------------------------------

// Single 1-bit AND cell.
module and_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

// 16-bit AND array built from and_gate cells.
module and16_gate (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] y_o
);
    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_bit
            and_gate u_cell (
                .a_i (a_i[g]),
                .b_i (b_i[g]),
                .y_o (y_o[g])
            );
        end
    endgenerate
endmodule

module and16_arbiter #(
    parameter int unsigned RR_RESET_PTR = 0
) (
    input  logic             clk,
    input  logic             reset,
    and16_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] PTR_RST = RR_RESET_PTR[1:0];

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  owner_q, owner_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  done_q, done_d;
    logic [15:0] and_y;
    logic [2:0]  pick;          // {valid, index} of the arbitration winner

    // Round-robin scan starting at 'start'. Offsets are visited from the
    // farthest to the nearest so the nearest requesting index wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] win;
        logic [1:0] idx;
        win = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + k[1:0];
            if (req[idx]) begin
                win = {1'b1, idx};
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // The one shared AND array.
    and16_gate u_and (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .y_o (and_y)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        gnt_d    = 4'b0000;
        done_d   = 4'b0000;
        pick     = 3'b000;

        case (state_q)
            IDLE: begin
                // Grants from IDLE are always plain round-robin.
                pick = rr_pick(bus.req, ptr_q);
            end
            EXEC: begin
                result_d = and_y;
                done_d   = onehot(owner_q);
                state_d  = DONE;
            end
            DONE: begin
                // Previous owner drops to lowest priority for this scan.
                ptr_d = owner_q + 2'd1;
                pick  = rr_pick(bus.req, ptr_d);
`ifdef AND16_ARB_LOCK_EN
                if (bus.lock[owner_q] && bus.req[owner_q]) begin
                    ptr_d = ptr_q;
                    pick  = {1'b1, owner_q};
                end
`endif
                if (!pick[2]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pick[2]) begin
            owner_d = pick[1:0];
            op_a_d  = bus.a_bus[{pick[1:0], 4'b0000} +: 16];
            op_b_d  = bus.b_bus[{pick[1:0], 4'b0000} +: 16];
            gnt_d   = onehot(pick[1:0]);
            state_d = EXEC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= PTR_RST;
            owner_q  <= 2'd0;
            gnt_q    <= 4'b0000;
            done_q   <= 4'b0000;
            result_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Operand registers are only meaningful after a grant, so they carry no reset.
    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_and16_arbiter.sv
module tb_and16_arbiter;
    typedef struct packed {
        logic [3:0]  who;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    and16_arbiter_if bus ();

    and16_arbiter #(.RR_RESET_PTR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.a_bus[16*i +: 16] = a;
        bus.b_bus[16*i +: 16] = b;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.req   = 4'b0000;
        bus.a_bus = '0;
        bus.b_bus = '0;
`ifdef AND16_ARB_LOCK_EN
        bus.lock  = 4'b0000;
`endif
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.req   = 4'b1111;
        bus.a_bus = {64{1'b1}};
        bus.b_bus = {64{1'b1}};
`ifdef AND16_ARB_LOCK_EN
        bus.lock  = 4'b0000;
`endif
        tick();
        tick();
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
        total++; if (bus.done !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b want=0000", bus.done); end
        total++; if (bus.result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", bus.result); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        reset   = 1'b0;
        bus.req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
                bad++; $display("FAIL idle_hold busy=%b gnt=%b want busy=0 gnt=0000", bus.busy, bus.gnt);
            end
        end
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        set_ops(1, 16'hF0F0, 16'h3C3C);
        bus.req = 4'b0010;
        sb.push_back('{who: 4'b0010, val: 16'h3030});
        tick();
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL single_gnt got=%b want=0010", bus.gnt); end
        total++; if (bus.busy !== 1'b1 || bus.done !== 4'b0000) begin bad++; $display("FAIL single_exec busy=%b done=%b want busy=1 done=0000", bus.busy, bus.done); end
        bus.req = 4'b0000;
        tick();
        e = sb.pop_front();
        total++; if (bus.done !== e.who || bus.result !== e.val) begin bad++; $display("FAIL single_done done=%b result=%h want done=%b result=%h", bus.done, bus.result, e.who, e.val); end
        total++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin bad++; $display("FAIL single_donestate gnt=%b busy=%b want gnt=0000 busy=1", bus.gnt, bus.busy); end
        tick();
        total++; if (bus.busy !== 1'b0 || bus.done !== 4'b0000 || bus.result !== 16'h3030) begin
            bad++; $display("FAIL single_idle busy=%b done=%b result=%h want busy=0 done=0000 result=3030", bus.busy, bus.done, bus.result);
        end
    endtask

    task automatic test_contention();
        exp_t        e;
        logic [3:0]  w;
        logic [15:0] av [4] = '{16'hF00F, 16'h0FF0, 16'hAAAA, 16'h5555};
        logic [15:0] bv [4] = '{16'hFFFF, 16'h00FF, 16'hF0F0, 16'hFF00};
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, av[i], bv[i]);
        sb.push_back('{who: 4'b0001, val: 16'hF00F});
        sb.push_back('{who: 4'b0010, val: 16'h00F0});
        sb.push_back('{who: 4'b0100, val: 16'hA0A0});
        sb.push_back('{who: 4'b1000, val: 16'h5500});
        sb.push_back('{who: 4'b0001, val: 16'hF00F});
        bus.req = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k % 2 == 1) begin
                w = 4'b0001 << (((k - 1) / 2) % 4);
                total++; if (bus.gnt !== w || bus.done !== 4'b0000) begin
                    bad++; $display("FAIL contention_gnt cycle=%0d gnt=%b done=%b want gnt=%b done=0000", k, bus.gnt, bus.done, w);
                end
            end else begin
                if (sb.size() == 0) begin
                    total++; bad++; $display("FAIL contention_sb cycle=%0d queue empty", k);
                end else begin
                    e = sb.pop_front();
                    total++; if (bus.done !== e.who || bus.result !== e.val || bus.gnt !== 4'b0000) begin
                        bad++; $display("FAIL contention_done cycle=%0d done=%b result=%h gnt=%b want done=%b result=%h gnt=0000", k, bus.done, bus.result, bus.gnt, e.who, e.val);
                    end
                end
            end
        end
        bus.req = 4'b0000;
        tick();
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL contention_idle busy=%b want=0", bus.busy); end
    endtask

    task automatic test_operand_hold();
        exp_t e;
        do_reset();
        set_ops(2, 16'hFFFF, 16'h00FF);
        bus.req = 4'b0100;
        sb.push_back('{who: 4'b0100, val: 16'h00FF});
        tick();
        total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL hold_gnt got=%b want=0100", bus.gnt); end
        set_ops(2, 16'h0000, 16'h00FF);
        bus.req = 4'b0000;
        tick();
        e = sb.pop_front();
        total++; if (bus.done !== e.who || bus.result !== e.val) begin bad++; $display("FAIL hold_result done=%b result=%h want done=%b result=%h", bus.done, bus.result, e.who, e.val); end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        set_ops(3, 16'h1234, 16'hFF00);
        bus.req = 4'b1000;
        sb.push_back('{who: 4'b1000, val: 16'h1200});
        tick();
        total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL b2b_gnt1 got=%b want=1000", bus.gnt); end
        set_ops(3, 16'hABCD, 16'h0F0F);
        sb.push_back('{who: 4'b1000, val: 16'h0B0D});
        tick();
        e = sb.pop_front();
        total++; if (bus.done !== e.who || bus.result !== e.val) begin bad++; $display("FAIL b2b_done1 done=%b result=%h want done=%b result=%h", bus.done, bus.result, e.who, e.val); end
        tick();
        total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL b2b_gnt2 got=%b want=1000", bus.gnt); end
        bus.req = 4'b0000;
        tick();
        e = sb.pop_front();
        total++; if (bus.done !== e.who || bus.result !== e.val) begin bad++; $display("FAIL b2b_done2 done=%b result=%h want done=%b result=%h", bus.done, bus.result, e.who, e.val); end
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle busy=%b want=0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        set_ops(0, 16'hAAAA, 16'hFFFF);
        bus.req = 4'b0001;
        sb.push_back('{who: 4'b0001, val: 16'hAAAA});
        tick();
        bus.req = 4'b0000;
        tick();
        e = sb.pop_front();
        total++; if (bus.done !== e.who || bus.result !== e.val) begin bad++; $display("FAIL mid_pre done=%b result=%h want done=%b result=%h", bus.done, bus.result, e.who, e.val); end
        tick();
        set_ops(1, 16'hFFFF, 16'hFFFF);
        bus.req = 4'b0010;
        tick();
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL mid_gnt got=%b want=0010", bus.gnt); end
        reset   = 1'b1;
        bus.req = 4'b0000;
        tick();
        total++; if (bus.done !== 4'b0000 || bus.result !== 16'h0000 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            bad++; $display("FAIL mid_reset done=%b result=%h busy=%b gnt=%b want 0000/0000/0/0000", bus.done, bus.result, bus.busy, bus.gnt);
        end
        reset = 1'b0;
        tick();
        total++; if (bus.done !== 4'b0000) begin bad++; $display("FAIL mid_nodone got=%b want=0000", bus.done); end
        set_ops(0, 16'h0F0F, 16'h3333);
        bus.req = 4'b0011;
        sb.push_back('{who: 4'b0001, val: 16'h0303});
        tick();
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL mid_ptr gnt=%b want=0001", bus.gnt); end
        bus.req = 4'b0000;
        tick();
        e = sb.pop_front();
        total++; if (bus.done !== e.who || bus.result !== e.val) begin bad++; $display("FAIL mid_post done=%b result=%h want done=%b result=%h", bus.done, bus.result, e.who, e.val); end
        tick();
    endtask

`ifdef AND16_ARB_LOCK_EN
    task automatic test_lock();
        exp_t       e;
        logic [3:0] w;
        do_reset();
        set_ops(0, 16'hFFFF, 16'h1357);
        set_ops(1, 16'hFFFF, 16'h2468);
        for (int i = 0; i < 3; i++) sb.push_back('{who: 4'b0001, val: 16'h1357});
        sb.push_back('{who: 4'b0010, val: 16'h2468});
        bus.lock = 4'b0001;
        bus.req  = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 1) begin
                w = (k == 7) ? 4'b0010 : 4'b0001;
                total++; if (bus.gnt !== w) begin bad++; $display("FAIL lock_gnt cycle=%0d gnt=%b want=%b", k, bus.gnt, w); end
            end else if (sb.size() == 0) begin
                total++; bad++; $display("FAIL lock_sb cycle=%0d queue empty", k);
            end else begin
                e = sb.pop_front();
                total++; if (bus.done !== e.who || bus.result !== e.val) begin
                    bad++; $display("FAIL lock_done cycle=%0d done=%b result=%h want done=%b result=%h", k, bus.done, bus.result, e.who, e.val);
                end
            end
            if (k == 6) bus.lock = 4'b0000;
            if (k == 7) bus.req = 4'b0000;
        end
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL lock_idle busy=%b want=0", bus.busy); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        bus.req   = 4'b0000;
        bus.a_bus = '0;
        bus.b_bus = '0;
`ifdef AND16_ARB_LOCK_EN
        bus.lock  = 4'b0000;
`endif
        test_reset();
        test_single();
        test_contention();
        test_operand_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef AND16_ARB_LOCK_EN
        test_lock();
`endif
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/and16_arbiter.md
# and16_arbiter

Sequencing arbiter that shares one 16-bit bitwise AND datapath (an instance of `and16_gate` built from `and_gate` cells) between four requesters. Arbitration is round-robin. Grants use a req/gnt handshake. Operands are captured into registers, evaluated through the shared unit, and returned on a registered result bus with a per-requester done pulse. It sits between the CPU-side logic users (ALU mask path, memory-mapped I/O masking, screen/keyboard helpers) and the single shared AND array.

## Interface
- `RR_RESET_PTR`, default 0: requester index (0–3) that holds highest priority after reset.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input 4: one request bit per requester. Held high until that requester's `gnt` is seen.
- `a_bus` input 64: operand A, requester i on bits [16i+15:16i].
- `b_bus` input 64: operand B, same packing as `a_bus`.
- `gnt` output 4: one-hot, one-cycle pulse. Indicates operands were captured.
- `done` output 4: one-hot, one-cycle pulse. Indicates `result` is valid for that requester.
- `result` output 16: AND of the captured operands. Held until the next op completes.
- `busy` output 1: high in EXEC and DONE.
- `lock` input 4: present only with `AND16_ARB_LOCK_EN` (see Configuration).

## Operation
- Registers:
  - `state` is one of {IDLE, EXEC, DONE}.
  - `ptr[1:0]` is the priority pointer.
  - `owner[1:0]` is the requester being served.
  - `op_a[15:0]` and `op_b[15:0]` hold the captured operands.
  - `result`, `gnt`, `done`.
- Arbitration function, evaluated in IDLE and DONE:
  - Winner is the first index with `req` high, scanning `ptr`, `ptr+1`, … mod 4.
  - On a winner: `owner` ← winner, `op_a`/`op_b` ← that requester's slice, `gnt` ← onehot(winner), `state` ← EXEC.
- IDLE:
  - No request: stay in IDLE, `gnt` = 0.
  - Otherwise arbitrate.
- EXEC: `result` ← `op_a & op_b` through the single shared `and16_gate` instance, `state` ← DONE, `gnt` ← 0.
- DONE:
  - `done` ← onehot(`owner`) for exactly this cycle.
  - `ptr` ← `owner`+1 mod 4.
  - Arbitrate again using the updated pointer, so the previous owner has lowest priority. With a winner, go to EXEC; otherwise go to IDLE.
- `req` is sampled only in IDLE and DONE. Operand changes after `gnt` have no effect.
- Only one AND array exists. No requester ever has a second op in flight.

## Timing
- Reset values: `state`=IDLE, `ptr`=`RR_RESET_PTR`, `owner`=0, `gnt`=0, `done`=0, `result`=0, `busy`=0.
- Latency: `req` sampled at edge t → `gnt` high during t+1 → `done` high and `result` valid during t+2.
- Throughput: one op per 2 cycles under continuous demand (DONE overlaps the next grant). An isolated op takes 3 cycles, including the return to IDLE.
- Handshake:
  - A requester drops `req` in the cycle after it sees `gnt`.
  - A `req` still high in DONE is treated as a new request.
- Simultaneous requests: resolved purely by the round-robin order from `ptr`. All four requesting continuously are served 0,1,2,3,0,… when `ptr` starts at 0.
- Reset in EXEC or DONE: the op is dropped, no `done` is issued, and all registers return to their reset values on that edge.
- `result` is never cleared except by reset. It is overwritten only at the EXEC edge.

## Configuration
- `AND16_ARB_LOCK_EN` defined:
  - Adds the `lock[3:0]` input.
  - In DONE, if `lock[owner]` and `req[owner]` are both high, `owner` is re-granted regardless of `ptr`, and `ptr` is not advanced.
  - Lock is honored in DONE only. Grants from IDLE are always plain round-robin.
- Undefined: the `lock` port does not exist and arbitration is strict round-robin.

## Test plan
- Reset: `req`=0000 → `gnt`=0, `done`=0, `result`=0x0000, `busy`=0, and the block stays in IDLE.
- Single op: `req`=0010, slice1 A=0xF0F0, B=0x3C3C → `gnt`=0010 at t+1, `done`=0010 and `result`=0x3030 at t+2, IDLE at t+3.
- Contention: `req`=1111 held continuously with `ptr`=0 → `gnt` sequence 0001, 0010, 0100, 1000, 0001 at 2-cycle spacing.
- Operand hold: after `gnt`, change A to 0x0000 → `result` still reflects the captured operands (0xFFFF & 0x00FF = 0x00FF).
- Reset mid-op: assert `reset` in EXEC → no `done` pulse, `result`=0, `ptr`=`RR_RESET_PTR`.
- With `AND16_ARB_LOCK_EN`: `lock`=0001 and `req`=0011 held → requester 0 is re-granted every op. Dropping `lock` lets requester 1 win next.
